// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// Holds the FSM state encoding, the registered result codes, and a helper
// that maps the first differing bit pair to a winner.
package serial_cmp_pkg;

  // Comparator FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Registered result codes; the output flags are decoded from these.
  localparam logic [1:0] EQ   = 2'd0;
  localparam logic [1:0] GT_A = 2'd1;
  localparam logic [1:0] GT_B = 2'd2;

  // Winner of the first differing pair. 'invert' flips the sense, which is
  // how a two's-complement sign bit behaves (A=1 there means A is negative).
  function automatic logic [1:0] pick_winner(input logic a_bit, input logic invert);
    return (a_bit ^ invert) ? GT_A : GT_B;
  endfunction

endpackage

// File: rtl/serial_comparator.sv
// Bit-serial comparator: consumes WIDTH bit pairs MSB first, decides on the
// first differing pair, and presents EQ / GT_A / GT_B flags one cycle after
// the last bit. Optional build macro: SERIAL_CMP_SIGNED_EN selects
// two's-complement operands (a difference on the MSB inverts the winner);
// without it operands are unsigned.
module serial_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_valid,
  input  logic i_a_bit,
  input  logic i_b_bit,
  output logic o_ready,
  output logic o_busy,
  output logic o_done,
  output logic o_result_valid,
  output logic o_equal,
  output logic o_not_equal,
  output logic o_great_a,
  output logic o_great_b
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_decided;
  logic [1:0]       r_code;
  logic             r_result_valid;

  logic w_accept;
  logic w_last;
  logic w_first_diff;
  logic w_invert;

  // A pair is taken only in SHIFT; a start in the same cycle restarts instead.
  assign w_accept     = (r_state == SHIFT) && i_valid && !i_start;
  assign w_last       = w_accept && (r_cnt == LAST_IDX);
  assign w_first_diff = w_accept && (i_a_bit != i_b_bit) && !r_decided;

`ifdef SERIAL_CMP_SIGNED_EN
  // Counter value 0 marks the MSB, i.e. the sign bit.
  assign w_invert = (r_cnt == '0);
`else
  assign w_invert = 1'b0;
`endif

  // FSM, bit counter, decision latch and result register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_decided      <= 1'b0;
      r_code         <= EQ;
      r_result_valid <= 1'b0;
    end else if (i_start) begin
      // Start from any state (re)begins a comparison and clears the result.
      r_state        <= SHIFT;
      r_cnt          <= '0;
      r_decided      <= 1'b0;
      r_code         <= EQ;
      r_result_valid <= 1'b0;
    end else begin
      case (r_state)
        SHIFT: begin
          if (w_accept) begin
            // Hold the counter on the last bit so it never wraps.
            if (!w_last) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_first_diff) begin
              r_decided <= 1'b1;
              r_code    <= pick_winner(i_a_bit, w_invert);
            end
            if (w_last) begin
              r_state        <= DONE;
              r_result_valid <= 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake and status decode from the registered state.
  assign o_ready = (r_state == SHIFT);
  assign o_busy  = (r_state == SHIFT) || (r_state == DONE);
  assign o_done  = (r_state == DONE);

  // Flag decode from the registered result code; all zero until a result exists.
  assign o_result_valid = r_result_valid;
  assign o_equal        = r_result_valid && (r_code == EQ);
  assign o_not_equal    = r_result_valid && (r_code != EQ);
  assign o_great_a      = r_result_valid && (r_code == GT_A);
  assign o_great_b      = r_result_valid && (r_code == GT_B);

endmodule
